// File: rtl/keypad_decoder.sv
// Keypad receive side: aligns row strobes with synchronized column returns,
// builds one key result per scan frame, and debounces press/release across frames.
module keypad_decoder #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic [3:0] row,
  input  logic [2:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_release,
  output logic       multi_key
);
  localparam logic [15:0] SETTLE_MAX = 16'(SETTLE_CYCLES);
  localparam logic [3:0]  STABLE_MAX = 4'(STABLE_FRAMES);

  typedef enum logic [1:0] {ACC_NONE, ACC_ONE, ACC_MULTI} acc_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMING, ST_PRESSED, ST_RELEASING} st_e;

  logic [2:0]  col_s1_q, col_s2_q;
  logic [3:0]  row_d1_q, row_d2_q, row_prev_q;
  logic [15:0] settle_q, settle_d;
  acc_e        acc_q, acc_d, fold_st;
  logic [3:0]  acc_key_q, acc_key_d, fold_key;
  st_e         st_q, st_d;
  logic [3:0]  cand_q, cand_d, cnt_q, cnt_d, cnt_inc;
  logic        first_q, first_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        valid_q, valid_d, held_q, held_d, release_q, release_d, multi_q, multi_d;

  logic        row_chg, sample, boundary, res_key;
  logic [1:0]  r_idx, c_idx, ncol;
  logic [3:0]  samp_key;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      col_s1_q   <= '0;
      col_s2_q   <= '0;
      row_d1_q   <= '0;
      row_d2_q   <= '0;
      row_prev_q <= '0;
      settle_q   <= '0;
      acc_q      <= ACC_NONE;
      acc_key_q  <= '0;
      st_q       <= ST_IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b1;
      key_code_q <= 4'hF;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
      release_q  <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      col_s1_q   <= col;
      col_s2_q   <= col_s1_q;
      row_d1_q   <= row;
      row_d2_q   <= row_d1_q;
      row_prev_q <= row_d2_q;
      settle_q   <= settle_d;
      acc_q      <= acc_d;
      acc_key_q  <= acc_key_d;
      st_q       <= st_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      key_code_q <= key_code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
      release_q  <= release_d;
      multi_q    <= multi_d;
    end
  end

  // Sampling and frame accumulation on the aligned row/col pair
  always_comb begin
    row_chg  = row_d2_q != row_prev_q;
    // the change cycle is excluded so a stale count never samples a fresh row
    sample   = !row_chg && $onehot(row_d2_q) && (settle_q == SETTLE_MAX);
    boundary = (row_d2_q == 4'b0001) && (row_prev_q != 4'b0001);
    settle_d = row_chg ? 16'd0 : (settle_q == SETTLE_MAX) ? settle_q : settle_q + 16'd1;

    r_idx = 2'd0;
    case (row_d2_q)
      4'b0010: r_idx = 2'd1;
      4'b0100: r_idx = 2'd2;
      4'b1000: r_idx = 2'd3;
      default: r_idx = 2'd0;
    endcase
    c_idx = col_s2_q[0] ? 2'd0 : col_s2_q[1] ? 2'd1 : 2'd2;
    ncol  = 2'($countones(col_s2_q));
    if (r_idx == 2'd3) samp_key = (c_idx == 2'd0) ? 4'd10 : (c_idx == 2'd1) ? 4'd0 : 4'd11;
    else               samp_key = {2'b00, r_idx} * 4'd3 + {2'b00, c_idx} + 4'd1;

    fold_st  = acc_q;
    fold_key = acc_key_q;
    if (sample && ncol != 2'd0) begin
      if (ncol > 2'd1) fold_st = ACC_MULTI;
      else if (acc_q == ACC_NONE) begin
        fold_st  = ACC_ONE;
        fold_key = samp_key;
      end else if (acc_q == ACC_ONE && acc_key_q != samp_key) fold_st = ACC_MULTI;
    end
    acc_d     = boundary ? ACC_NONE : fold_st;
    acc_key_d = fold_key;
  end

  // Debounce across frame results
  always_comb begin
    st_d       = st_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    key_code_d = key_code_q;
    held_d     = held_q;
    valid_d    = 1'b0;
    release_d  = 1'b0;
    multi_d    = 1'b0;
    res_key    = fold_st == ACC_ONE;
    cnt_inc    = cnt_q + 4'd1;
    if (boundary) begin
      first_d = 1'b0;
      if (!first_q) begin
        multi_d = fold_st == ACC_MULTI;
        case (st_q)
          ST_IDLE: if (res_key) begin
            st_d   = ST_ARMING;
            cand_d = fold_key;
            cnt_d  = 4'd1;
          end
          ST_ARMING: begin
            if (res_key && fold_key == cand_q) begin
              cnt_d = cnt_inc;
              if (cnt_inc == STABLE_MAX) begin
                st_d       = ST_PRESSED;
                key_code_d = cand_q;
                valid_d    = 1'b1;
                held_d     = 1'b1;
              end
            end else if (res_key) begin
              cand_d = fold_key;
              cnt_d  = 4'd1;
            end else st_d = ST_IDLE;
          end
          ST_PRESSED: if (!(res_key && fold_key == key_code_q)) begin
            st_d  = ST_RELEASING;
            cnt_d = 4'd1;
          end
          ST_RELEASING: begin
            if (res_key && fold_key == key_code_q) st_d = ST_PRESSED;
            else begin
              cnt_d = cnt_inc;
              if (cnt_inc == STABLE_MAX) begin
                st_d      = ST_IDLE;
                held_d    = 1'b0;
                release_d = 1'b1;
              end
            end
          end
          default: st_d = ST_IDLE;
        endcase
      end
    end
  end

  assign key_code    = key_code_q;
  assign key_valid   = valid_q;
  assign key_held    = held_q;
  assign key_release = release_q;
  assign multi_key   = multi_q;
endmodule

// File: tb/tb_keypad_decoder.sv
// Frame-level scoreboard bench: drives keypad frames from key-set masks and
// compares every output pulse against a model of frame results and debouncing.
module tb_keypad_decoder;
  localparam int SETTLE = 2;
  localparam int STABLE = 3;
  localparam int DWELL  = 8;

  logic       clk = 1'b0;
  logic       init_n = 1'b0;
  logic [3:0] row = 4'b0000;
  logic [2:0] col = 3'b000;
  logic [3:0] key_code;
  logic       key_valid, key_held, key_release, multi_key;

  keypad_decoder #(.SETTLE_CYCLES(SETTLE), .STABLE_FRAMES(STABLE)) dut (
    .clk(clk), .init_n(init_n), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
    .key_release(key_release), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit v; bit r; bit m; logic [3:0] code; bit held; int cyc;
  } ev_t;
  ev_t q[$];

  int checks = 0, errors = 0;

  // model state
  logic [11:0] prev_mask = '0;
  bit          first = 1'b1, held = 1'b0;
  int          run = 0, miss = 0, run_key = 0;
  logic [3:0]  code = 4'hF;

  function automatic int key_at(int r, int c);
    if (r == 3) return (c == 0) ? 10 : (c == 1) ? 0 : 11;
    return 3 * r + c + 1;
  endfunction

  function automatic logic [11:0] km(int k);
    logic [11:0] m;
    m = '0;
    m[k] = 1'b1;
    return m;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Evaluate the frame that just closed; pulses expected 3 edges after row=0001 is driven
  task automatic model_boundary(int p);
    ev_t e;
    int  n, k;
    if (first) first = 1'b0;
    else begin
      n = $countones(prev_mask);
      k = 0;
      for (int i = 0; i < 12; i++) if (prev_mask[i]) k = i;
      e.v = 1'b0; e.r = 1'b0; e.m = (n > 1); e.cyc = p + 3;
      if (!held) begin
        if (n == 1 && run > 0 && k == run_key) run++;
        else if (n == 1) begin run = 1; run_key = k; end
        else run = 0;
        if (run == STABLE) begin
          held = 1'b1; code = 4'(k); e.v = 1'b1; run = 0; miss = 0;
        end
      end else begin
        if (n == 1 && 4'(k) == code) miss = 0;
        else miss++;
        if (miss == STABLE) begin
          held = 1'b0; e.r = 1'b1; miss = 0; run = 0;
        end
      end
      e.code = code;
      e.held = held;
      if (e.v || e.r || e.m) q.push_back(e);
    end
  endtask

  task automatic do_reset();
    #2 init_n = 1'b0;
    #1;
    check("rst_async_code", int'(key_code), 15);
    check("rst_async_held", int'(key_held), 0);
    check("rst_async_pulses", int'({key_valid, key_release, multi_key}), 0);
    first = 1'b1; held = 1'b0; run = 0; miss = 0; code = 4'hF;
    #3 init_n = 1'b1;
  endtask

  task automatic run_frame(logic [11:0] mask, bit rst_mid);
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #1;
      row = 4'(1 << r);
      for (int c = 0; c < 3; c++) col[c] = mask[key_at(r, c)];
      if (r == 0) begin
        model_boundary(cyc);
        prev_mask = mask;
      end
      for (int w = 1; w < DWELL; w++) begin
        @(posedge clk); #1;
        if (rst_mid && r == 2 && w == 3) do_reset();
      end
    end
  endtask

  task automatic rep(logic [11:0] mask, int n);
    for (int i = 0; i < n; i++) run_frame(mask, 1'b0);
  endtask

  // Monitor: every pulse cycle must match the next expected event
  always @(negedge clk) begin
    ev_t e;
    if (init_n && (key_valid || key_release || multi_key)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d v=%b r=%b m=%b code=%0d",
                 cyc, key_valid, key_release, multi_key, key_code);
      end else begin
        e = q.pop_front();
        if ({key_valid, key_release, multi_key} != {e.v, e.r, e.m} ||
            key_code !== e.code || key_held !== e.held || cyc != e.cyc) begin
          errors++;
          $display("FAIL event actual v=%b r=%b m=%b code=%0d held=%b cyc=%0d expected v=%b r=%b m=%b code=%0d held=%b cyc=%0d",
                   key_valid, key_release, multi_key, key_code, key_held, cyc,
                   e.v, e.r, e.m, e.code, e.held, e.cyc);
        end
      end
    end
  end

  initial begin
    logic [11:0] m;
    int sel;
    repeat (3) @(posedge clk);
    #1;
    check("reset_code", int'(key_code), 15);
    check("reset_valid", int'(key_valid), 0);
    check("reset_held", int'(key_held), 0);
    check("reset_release", int'(key_release), 0);
    check("reset_multi", int'(multi_key), 0);
    init_n = 1'b1;

    rep(km(5), 4);                 // press 5
    rep('0, 3);                    // release 5
    check("code_after_release", int'(key_code), 5);
    rep(km(0), 2); rep('0, 1); rep(km(0), 3); rep('0, 3);
    rep(km(1) | km(2), 2);         // col 011 in top row
    rep(km(1) | km(9), 2);         // two rows in one frame
    rep('0, 2);
    rep(km(11), 3); rep('0, 1); rep(km(11), 2);
    run_frame(km(11), 1'b1);       // reset while held
    rep(km(11), 4);
    rep('0, 3);

    m = '0;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 50) m = m;
      else if (sel < 62) m = '0;
      else if (sel < 88) m = km(int'($urandom_range(0, 11)));
      else m = km(int'($urandom_range(0, 11))) | km(int'($urandom_range(0, 11)));
      run_frame(m, 1'b0);
    end
    rep('0, 4);
    repeat (10) @(posedge clk);
    #1;
    check("pending_events", q.size(), 0);
    check("final_code", int'(key_code), int'(code));
    check("final_held", int'(key_held), int'(held));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_decoder.md
# keypad_decoder

Receive-side companion to the keypad row scanner. The scanner drives one-hot row strobes; this block pairs each strobe with the returned column lines. It assembles one key result per scan frame and debounces across frames. It then presents a single clean key code with press/release pulses to the safe controller. It also flags multi-key (ghost) frames.

## Interface
Parameters:
- SETTLE_CYCLES, 16: cycles a row strobe must be stable before columns are sampled (1..65535).
- STABLE_FRAMES, 3: consecutive identical frame results required to accept a press or a release (2..15).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- init_n  input  1  asynchronous, active-low reset.
- row  input  4  one-hot row strobe from the scanner; row[0] is the top row (keys 1,2,3).
- col  input  3  column return lines from the keypad, active-high, asynchronous to clk.
- key_code  output  4  last accepted key: 0-9 = digit, 10 = '*', 11 = '#', 4'b1111 = none.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  level; high from acceptance until release is accepted.
- key_release  output  1  one-cycle pulse when a release is accepted.
- multi_key  output  1  one-cycle pulse at a frame boundary whose frame saw more than one key.

## Operation
- Input alignment:
  - col passes a 2-flop synchronizer.
  - row is delayed by 2 registers (row_d) to stay aligned with col.
  - All logic uses the aligned versions.
- Settle counter:
  - Clears whenever row_d changes; otherwise increments, saturating at SETTLE_CYCLES.
  - Sampling is enabled only when the counter equals SETTLE_CYCLES and row_d is exactly one-hot.
  - Non-one-hot rows (4'b0000 or multiple bits set) never sample.
- Key map: row index r (0..3), col index c (0..2).
  - Rows 0-2: code = 3r+c+1.
  - Row 3: c=0 gives 10 ('*'), c=1 gives 0, c=2 gives 11 ('#').
- Frame accumulator states are NONE, ONE(k) and MULTI.
  - A sample with exactly one col bit set: NONE→ONE(k); ONE(k) with a different key → MULTI.
  - A sample with two or more col bits set → MULTI.
  - MULTI is sticky until the next frame boundary.
- Frame boundary: the cycle in which row_d becomes 4'b0001 from any other value.
  - The accumulated result is evaluated and the accumulator returns to NONE.
  - The first boundary after reset evaluates nothing (partial frame discarded).
  - A MULTI result pulses multi_key and counts as "not a key" below.
- Debounce FSM, with cand and cnt[3:0]:
  - IDLE: result key k → ARMING, cand=k, cnt=1.
  - ARMING:
    - Result == cand → cnt+1; on reaching STABLE_FRAMES → PRESSED, key_code=cand, key_valid pulse, key_held=1.
    - Another key → cand=new, cnt=1.
    - NONE or MULTI → IDLE.
  - PRESSED: result == key_code → stay; anything else → RELEASING, cnt=1.
  - RELEASING:
    - Result == key_code → PRESSED, with no pulse.
    - Otherwise cnt+1; on reaching STABLE_FRAMES → IDLE, key_held=0, key_release pulse.
    - A different key pressed during RELEASING counts toward the release. It arms only from IDLE at the following boundary.
- key_code holds its value after release; it changes only on acceptance.
- Reset values:
  - key_code=4'b1111; key_valid, key_held, key_release, multi_key = 0.
  - FSM in IDLE; accumulator NONE; first-frame flag set; synchronizers 0.

## Timing
- Outputs are registered.
- Pulses last exactly one cycle. They are asserted in the cycle after the boundary cycle, which is 3 clk edges after row switches to 4'b0001.
- Press latency: STABLE_FRAMES full frames of the key, plus 3 cycles.
- Release latency: the same, counted in frames without the key.
- A column change within SETTLE_CYCLES of a row change is not sampled.
- A boundary cycle with a valid sample folds that sample into the closing frame, not the new one.
- init_n low clears all state immediately, regardless of clk. No pulse is generated on reset entry or exit.

## Test plan
Bench settings: SETTLE_CYCLES=2, STABLE_FRAMES=3, row dwell 8 cycles per strobe, sequence 0001→0010→0100→1000.
- Key 5 (col=3'b010 during row 4'b0010) for 4 boundaries → key_code=5, key_valid pulses once 3 edges after the 4th row=0001, key_held=1.
- Release key 5 for 3 frames → key_release pulses once, key_held=0, key_code stays 5, no key_valid.
- Key 0 (row 1000, col 010) present 2 frames, absent 1, present 3 → exactly one key_valid, code 0, only after the last 3 frames.
- Col 3'b011 during row 0001, or key 1 and key 9 in the same frame → multi_key pulse each frame, key_valid never asserts.
- '#' held and accepted, then 1 empty frame, then present again → no key_release, no second key_valid, key_code=11.
- Drop init_n mid-cycle while PRESSED → outputs reset the same cycle (key_code=1111, key_held=0); after release, no pulses until a new 3-frame press.
